// File: rtl/csr_pkg.sv
// Shared types and constants for the machine CSR access controller.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_READ = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } csr_state_e;

    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

    localparam int unsigned CY_BIT = 0;
    localparam int unsigned IR_BIT = 2;

    // RS/RC with an all-zero mask are pure reads; RW always writes.
    function automatic logic is_write_attempt(input csr_op_e op, input logic mask_nonzero);
        logic att;
        case (op)
            CSR_RW:         att = 1'b1;
            CSR_RS, CSR_RC: att = mask_nonzero;
            default:        att = 1'b0;
        endcase
        return att;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Double-width free-running counter with independently writable halves.
module csr_counter64 #(
    parameter int unsigned HalfWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     inc_i,
    input  logic                     wr_lo_i,
    input  logic                     wr_hi_i,
    input  logic [HalfWidth-1:0]     wdata_i,
    output logic [2*HalfWidth-1:0]   count_o
);

    localparam logic [2*HalfWidth-1:0] CntOne = {{(2*HalfWidth-1){1'b0}}, 1'b1};

    logic [2*HalfWidth-1:0] count_r;

    // Half writes win over the increment; the untouched half keeps its value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_r <= '0;
        end else if (wr_lo_i) begin
            count_r[HalfWidth-1:0] <= wdata_i;
        end else if (wr_hi_i) begin
            count_r[2*HalfWidth-1:HalfWidth] <= wdata_i;
        end else if (inc_i) begin
            count_r <= count_r + CntOne;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/csr_access_ctrl.sv
// Two-port arbitrated access to mcycle/minstret/mcountinhibit with a fixed
// IDLE->RD->WR->RSP read-modify-write sequence.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned DWidth = 32,
    parameter int unsigned AWidth = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  retire_i,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [1:0]            req0_op_i,
    input  logic [AWidth-1:0]     req0_addr_i,
    input  logic [DWidth-1:0]     req0_wdata_i,
    output logic                  rsp0_valid_o,
    output logic [DWidth-1:0]     rsp0_rdata_o,
    output logic                  rsp0_err_o,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [1:0]            req1_op_i,
    input  logic [AWidth-1:0]     req1_addr_i,
    input  logic [DWidth-1:0]     req1_wdata_i,
    output logic                  rsp1_valid_o,
    output logic [DWidth-1:0]     rsp1_rdata_o,
    output logic                  rsp1_err_o,
    output logic [2*DWidth-1:0]   cycle_o,
    output logic [2*DWidth-1:0]   instret_o
);

    csr_state_e          state_r;
    logic                last_gnt_r;   // 1: port 1 was granted last, so port 0 wins a tie
    logic                port_r;
    csr_op_e             op_r;
    logic [AWidth-1:0]   addr_r;
    logic [DWidth-1:0]   wdata_r;
    logic [DWidth-1:0]   rdata_r;
    logic                err_r;
    logic                cy_inh_r;
    logic                ir_inh_r;
    logic                rsp0_valid_r, rsp1_valid_r;
    logic [DWidth-1:0]   rsp0_rdata_r, rsp1_rdata_r;
    logic                rsp0_err_r, rsp1_err_r;

    logic                gnt0_s, gnt1_s;
    logic                legal_s, ro_s, wr_att_s, commit_s;
    logic                sel_cyc_lo_s, sel_cyc_hi_s, sel_ins_lo_s, sel_ins_hi_s, sel_inh_s;
    logic [DWidth-1:0]   rd_val_s, inh_val_s, new_val_s;
    logic [2*DWidth-1:0] cycle_cnt_s, instret_cnt_s;

    // Round-robin grant, only offered while idle.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt0_s = last_gnt_r;
                gnt1_s = ~last_gnt_r;
            end else begin
                gnt0_s = req0_valid_i;
                gnt1_s = req1_valid_i;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready_o = gnt0_s;
    assign req1_ready_o = gnt1_s;

    // Address decode and read mux for the latched request.
    always_comb begin
        legal_s      = 1'b1;
        ro_s         = 1'b0;
        sel_cyc_lo_s = 1'b0;
        sel_cyc_hi_s = 1'b0;
        sel_ins_lo_s = 1'b0;
        sel_ins_hi_s = 1'b0;
        sel_inh_s    = 1'b0;
        inh_val_s    = '0;
        inh_val_s[CY_BIT] = cy_inh_r;
        inh_val_s[IR_BIT] = ir_inh_r;
        rd_val_s     = '0;
        case (addr_r)
            AWidth'(ADDR_MCYCLE):        begin sel_cyc_lo_s = 1'b1; rd_val_s = cycle_cnt_s[DWidth-1:0]; end
            AWidth'(ADDR_MCYCLEH):       begin sel_cyc_hi_s = 1'b1; rd_val_s = cycle_cnt_s[2*DWidth-1:DWidth]; end
            AWidth'(ADDR_MINSTRET):      begin sel_ins_lo_s = 1'b1; rd_val_s = instret_cnt_s[DWidth-1:0]; end
            AWidth'(ADDR_MINSTRETH):     begin sel_ins_hi_s = 1'b1; rd_val_s = instret_cnt_s[2*DWidth-1:DWidth]; end
            AWidth'(ADDR_MCOUNTINHIBIT): begin sel_inh_s = 1'b1;    rd_val_s = inh_val_s; end
            AWidth'(ADDR_CYCLE):         begin ro_s = 1'b1; rd_val_s = cycle_cnt_s[DWidth-1:0]; end
            AWidth'(ADDR_CYCLEH):        begin ro_s = 1'b1; rd_val_s = cycle_cnt_s[2*DWidth-1:DWidth]; end
            AWidth'(ADDR_INSTRET):       begin ro_s = 1'b1; rd_val_s = instret_cnt_s[DWidth-1:0]; end
            AWidth'(ADDR_INSTRETH):      begin ro_s = 1'b1; rd_val_s = instret_cnt_s[2*DWidth-1:DWidth]; end
            default:                     begin legal_s = 1'b0; rd_val_s = '0; end
        endcase
    end

    // New value from the old value captured in RD; commit only in WR without error.
    always_comb begin
        wr_att_s = is_write_attempt(op_r, (wdata_r != '0));
        case (op_r)
            CSR_RW:  new_val_s = wdata_r;
            CSR_RS:  new_val_s = rdata_r | wdata_r;
            CSR_RC:  new_val_s = rdata_r & ~wdata_r;
            default: new_val_s = rdata_r;
        endcase
        commit_s = (state_r == ST_WR) && wr_att_s && !err_r;
    end

    csr_counter64 #(.HalfWidth(DWidth)) u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (~cy_inh_r),
        .wr_lo_i (commit_s & sel_cyc_lo_s),
        .wr_hi_i (commit_s & sel_cyc_hi_s),
        .wdata_i (new_val_s),
        .count_o (cycle_cnt_s)
    );

    csr_counter64 #(.HalfWidth(DWidth)) u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (retire_i & ~ir_inh_r),
        .wr_lo_i (commit_s & sel_ins_lo_s),
        .wr_hi_i (commit_s & sel_ins_hi_s),
        .wdata_i (new_val_s),
        .count_o (instret_cnt_s)
    );

    // Access sequencer: latch, read/check, write/respond, pulse response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            last_gnt_r   <= 1'b1;
            port_r       <= 1'b0;
            op_r         <= CSR_READ;
            addr_r       <= '0;
            wdata_r      <= '0;
            rdata_r      <= '0;
            err_r        <= 1'b0;
            cy_inh_r     <= 1'b0;
            ir_inh_r     <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_rdata_r <= '0;
            rsp1_rdata_r <= '0;
            rsp0_err_r   <= 1'b0;
            rsp1_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    if (gnt0_s || gnt1_s) begin
                        port_r     <= gnt1_s;
                        last_gnt_r <= gnt1_s;
                        op_r       <= gnt1_s ? csr_op_e'(req1_op_i) : csr_op_e'(req0_op_i);
                        addr_r     <= gnt1_s ? req1_addr_i : req0_addr_i;
                        wdata_r    <= gnt1_s ? req1_wdata_i : req0_wdata_i;
                        state_r    <= ST_RD;
                    end
                end
                ST_RD: begin
                    rdata_r <= rd_val_s;
                    err_r   <= !legal_s || (ro_s && wr_att_s);
                    state_r <= ST_WR;
                end
                ST_WR: begin
                    if (commit_s && sel_inh_s) begin
                        cy_inh_r <= new_val_s[CY_BIT];
                        ir_inh_r <= new_val_s[IR_BIT];
                    end
                    if (port_r) begin
                        rsp1_valid_r <= 1'b1;
                        rsp1_rdata_r <= rdata_r;
                        rsp1_err_r   <= err_r;
                    end else begin
                        rsp0_valid_r <= 1'b1;
                        rsp0_rdata_r <= rdata_r;
                        rsp0_err_r   <= err_r;
                    end
                    state_r <= ST_RSP;
                end
                ST_RSP: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid_o = rsp0_valid_r;
    assign rsp0_rdata_o = rsp0_rdata_r;
    assign rsp0_err_o   = rsp0_err_r;
    assign rsp1_valid_o = rsp1_valid_r;
    assign rsp1_rdata_o = rsp1_rdata_r;
    assign rsp1_err_o   = rsp1_err_r;
    assign cycle_o      = cycle_cnt_s;
    assign instret_o    = instret_cnt_s;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed + randomized bench for csr_access_ctrl against a transaction-level model.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [1:0]  op0 = 2'd0, op1 = 2'd0;
    logic [11:0] a0 = 12'd0, a1 = 12'd0;
    logic [31:0] wd0 = 32'd0, wd1 = 32'd0;
    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
    logic [63:0] cycle_o, instret_o;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    bit rand_retire = 1'b0;

    // Reference model state
    logic [63:0] m_cycle, m_instret;
    logic        m_cy, m_ir, m_last;
    int          pend_cnt;
    logic [11:0] pend_addr;
    logic [31:0] pend_val;

    logic [11:0] addr_tab [14];

    always #5 clk = ~clk;

    csr_access_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .retire_i     (retire),
        .req0_valid_i (v0),
        .req0_ready_o (rdy0),
        .req0_op_i    (op0),
        .req0_addr_i  (a0),
        .req0_wdata_i (wd0),
        .rsp0_valid_o (rv0),
        .rsp0_rdata_o (rd0),
        .rsp0_err_o   (er0),
        .req1_valid_i (v1),
        .req1_ready_o (rdy1),
        .req1_op_i    (op1),
        .req1_addr_i  (a1),
        .req1_wdata_i (wd1),
        .rsp1_valid_o (rv1),
        .rsp1_rdata_o (rd1),
        .rsp1_err_o   (er1),
        .cycle_o      (cycle_o),
        .instret_o    (instret_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cycle   = 64'd0;
        m_instret = 64'd0;
        m_cy      = 1'b0;
        m_ir      = 1'b0;
        m_last    = 1'b1;
        pend_cnt  = 0;
        pend_addr = 12'd0;
        pend_val  = 32'd0;
    endtask

    // One clock edge of the architectural counters.
    task automatic model_edge();
        logic apply, cyc_w, ins_w;
        if (rst) begin
            model_reset();
        end else begin
            apply = 1'b0;
            if (pend_cnt != 0) begin
                pend_cnt--;
                apply = (pend_cnt == 0);
            end
            cyc_w = apply && (pend_addr == 12'hB00 || pend_addr == 12'hB80);
            ins_w = apply && (pend_addr == 12'hB02 || pend_addr == 12'hB82);
            if (!cyc_w && !m_cy) m_cycle = m_cycle + 64'd1;
            if (!ins_w && !m_ir && retire) m_instret = m_instret + 64'd1;
            if (apply) begin
                case (pend_addr)
                    12'hB00: m_cycle[31:0]    = pend_val;
                    12'hB80: m_cycle[63:32]   = pend_val;
                    12'hB02: m_instret[31:0]  = pend_val;
                    12'hB82: m_instret[63:32] = pend_val;
                    12'h320: begin m_cy = pend_val[0]; m_ir = pend_val[2]; end
                    default: ;
                endcase
            end
        end
    endtask

    function automatic void m_read(input logic [11:0] a, output logic legal,
                                   output logic ro, output logic [31:0] v);
        legal = 1'b1;
        v = 32'd0;
        case (a)
            12'hB00, 12'hC00: v = m_cycle[31:0];
            12'hB80, 12'hC80: v = m_cycle[63:32];
            12'hB02, 12'hC02: v = m_instret[31:0];
            12'hB82, 12'hC82: v = m_instret[63:32];
            12'h320:          v = {29'd0, m_ir, 1'b0, m_cy};
            default:          legal = 1'b0;
        endcase
        ro = legal && (a[11:8] == 4'hC);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("cycle_o", cycle_o, m_cycle);
        chk("instret_o", instret_o, m_instret);
        if (rand_retire) retire = 1'($urandom_range(0, 1));
        else retire = 1'b0;
    endtask

    task automatic do_access(input int p, input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wd);
        logic legal, ro, watt, exp_err, both, rdy_me, rdy_other, rv_me, rv_other, er_me;
        logic [31:0] old, nv, rd_me;
        int waited, t_xfer;
        if (p == 0) begin v0 = 1'b1; op0 = op; a0 = addr; wd0 = wd; end
        else begin v1 = 1'b1; op1 = op; a1 = addr; wd1 = wd; end
        waited = 0;
        #1;
        rdy_me = (p == 0) ? rdy0 : rdy1;
        while (!rdy_me && waited < 16) begin
            step();
            #1;
            waited++;
            rdy_me = (p == 0) ? rdy0 : rdy1;
        end
        chk("grant", 64'(rdy_me), 64'd1);
        if (!rdy_me) begin
            if (p == 0) v0 = 1'b0; else v1 = 1'b0;
            return;
        end
        both = v0 && v1;
        rdy_other = (p == 0) ? rdy1 : rdy0;
        chk("other_ready", 64'(rdy_other), 64'd0);
        if (both) chk("arb_winner", 64'(p), (m_last == 1'b1) ? 64'd0 : 64'd1);
        m_last = (p == 1);
        t_xfer = cyc;
        last_xfer_cyc = cyc;
        step();
        // Requester is free to change its inputs after the transfer.
        if (p == 0) begin v0 = 1'b0; op0 = 2'($urandom); a0 = 12'($urandom); wd0 = $urandom; end
        else begin v1 = 1'b0; op1 = 2'($urandom); a1 = 12'($urandom); wd1 = $urandom; end
        m_read(addr, legal, ro, old);
        watt = (op == 2'd1) || (op != 2'd0 && wd != 32'd0);
        exp_err = !legal || (ro && watt);
        if (!exp_err && watt) begin
            case (op)
                2'd1:    nv = wd;
                2'd2:    nv = old | wd;
                default: nv = old & ~wd;
            endcase
            pend_cnt = 2;
            pend_addr = addr;
            pend_val = nv;
        end
        step();
        step();
        rv_me    = (p == 0) ? rv0 : rv1;
        rv_other = (p == 0) ? rv1 : rv0;
        rd_me    = (p == 0) ? rd0 : rd1;
        er_me    = (p == 0) ? er0 : er1;
        chk("rsp_valid", 64'(rv_me), 64'd1);
        chk("rsp_other_quiet", 64'(rv_other), 64'd0);
        chk("rsp_rdata", 64'(rd_me), 64'(old));
        chk("rsp_err", 64'(er_me), 64'(exp_err));
        chk("rsp_latency", 64'(cyc - t_xfer), 64'd3);
        step();
        chk("rsp_pulse_end", 64'(rv0 | rv1), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] snap_c, snap_i;
        int t_first;
        addr_tab = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320, 12'hC00, 12'hC80,
                     12'hC02, 12'hC82, 12'h7C0, 12'h321, 12'hB01, 12'hC01, 12'h000};
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_cycle", cycle_o, 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        chk("rst_ready", 64'({rdy0, rdy1}), 64'd0);
        chk("rst_rsp_valid", 64'({rv0, rv1}), 64'd0);
        chk("rst_rsp_data", 64'({rd0, er0}), 64'd0);
        rst = 1'b0;

        // Idle 10 cycles with 3 retires
        for (int i = 0; i < 10; i++) begin
            retire = (i == 2 || i == 5 || i == 7);
            step();
        end
        chk("idle_cycle", cycle_o, 64'd10);
        chk("idle_instret", instret_o, 64'd3);
        do_access(0, 2'd0, 12'hB02, 32'd0);

        // High-half write, then preload near wrap
        do_access(0, 2'd1, 12'hB80, 32'h1);
        chk("mcycleh_written", 64'(cycle_o[63:32]), 64'd1);
        do_access(0, 2'd1, 12'hB80, 32'hFFFF_FFFF);
        do_access(0, 2'd1, 12'hB00, 32'hFFFF_FFFE);
        chk("wrap_pre", cycle_o, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("wrap_zero", cycle_o, 64'd0);

        // Simultaneous requests, twice: port 0 then port 1
        do_access(1, 2'd0, 12'hC00, 32'd0);
        for (int k = 0; k < 2; k++) begin
            v1 = 1'b1; op1 = 2'd0; a1 = 12'hB02; wd1 = 32'd0;
            do_access(0, 2'd0, 12'hB00, 32'd0);
            t_first = last_xfer_cyc;
            do_access(1, 2'd0, 12'hB02, 32'd0);
            chk("b2b_spacing", 64'(last_xfer_cyc - t_first), 64'd4);
        end

        // mcountinhibit freeze / partial resume
        rand_retire = 1'b1;
        do_access(1, 2'd2, 12'h320, 32'h5);
        snap_c = m_cycle;
        snap_i = m_instret;
        repeat (5) step();
        chk("inh_cycle_frozen", cycle_o, snap_c);
        chk("inh_instret_frozen", instret_o, snap_i);
        do_access(1, 2'd3, 12'h320, 32'h1);
        snap_c = m_cycle;
        snap_i = m_instret;
        repeat (5) step();
        chk("inh_cycle_resumed", cycle_o, snap_c + 64'd5);
        chk("inh_instret_still", instret_o, snap_i);
        do_access(0, 2'd1, 12'h320, 32'h0);

        // Error cases
        do_access(0, 2'd1, 12'h7C0, 32'h1234);
        do_access(0, 2'd1, 12'hC00, 32'h0);
        do_access(0, 2'd2, 12'hC00, 32'h0);

        // Reset during the WR cycle of an RW to mcycle
        v0 = 1'b1; op0 = 2'd1; a0 = 12'hB00; wd0 = 32'h1234_5678;
        #1;
        chk("rstmid_ready", 64'(rdy0), 64'd1);
        step();
        v0 = 1'b0;
        step();
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rstmid_async_cycle", cycle_o, 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid_no_rsp", 64'(rv0 | rv1), 64'd0);
        end
        chk("rstmid_rdata", 64'(rd0), 64'd0);
        do_access(0, 2'd0, 12'hB00, 32'd0);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            int p;
            logic [1:0] op;
            logic [11:0] ad;
            logic [31:0] w;
            p  = int'($urandom_range(0, 1));
            op = 2'($urandom);
            ad = addr_tab[$urandom_range(0, 13)];
            w  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_access(p, op, ad, w);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
Controller for the scalar core's machine CSR file and performance counters.
- Owns the 64-bit mcycle/minstret counters and the mcountinhibit register.
- Arbitrates CSR accesses from two requesters: the core pipeline (port 0) and the host/debug interface (port 1).
- Sequences atomic read-modify-write operations (CSRRW/CSRRS/CSRRC) through a fixed-latency FSM.

Parameters:
- DWidth, 32, CSR data width; counters are DWidth*2 bits.
- AWidth, 12, CSR address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- retire_i  in  1  one-cycle pulse per retired instruction
- req0_valid_i  in  1  port 0 request valid
- req0_ready_o  out  1  port 0 request accepted this cycle
- req0_op_i  in  2  0=READ, 1=RW, 2=RS, 3=RC
- req0_addr_i  in  AWidth  CSR address
- req0_wdata_i  in  DWidth  write data / bit mask
- rsp0_valid_o  out  1  port 0 response pulse
- rsp0_rdata_o  out  DWidth  old CSR value
- rsp0_err_o  out  1  illegal access flag
- req1_*/rsp1_*  same set as port 0, for port 1
- cycle_o  out  DWidth*2  current mcycle
- instret_o  out  DWidth*2  current minstret

Behaviour:
- Reset values: all outputs 0; counters 0; mcountinhibit 0; FSM in IDLE; round-robin pointer favours port 0.
- Address map:
  - 0xB00/0xB80: mcycle low/high, RW.
  - 0xB02/0xB82: minstret low/high, RW.
  - 0x320: mcountinhibit, RW; only bits 0 (CY) and 2 (IR) are implemented, other bits read 0.
  - 0xC00/0xC80/0xC02/0xC82: read-only shadows of the same counters.
  - Any other address is illegal.
- Counters:
  - mcycle increments every cycle while CY=0.
  - minstret increments on retire_i while IR=0.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to either half of a counter replaces that half with the write value. The counter does not increment in that cycle; the other half keeps its value.
- Handshake:
  - ready is driven only in IDLE. A transfer occurs on valid&ready, and ready is a one-cycle pulse.
  - op, addr and wdata are latched on transfer; the requester may then change its inputs.
  - A requester holds valid until it sees ready.
  - The non-granted requester sees ready=0 and keeps waiting.
- Arbitration:
  - If only one port is valid in IDLE, grant it.
  - If both are valid, grant the port not granted last, then toggle the pointer.
- FSM (IDLE -> RD -> WR -> RSP -> IDLE):
  - IDLE: arbitrate. On a grant, latch the request and go to RD.
  - RD: capture the old value from the read mux into the rdata register, and evaluate legality.
  - WR: compute the new value and commit it.
    - RW writes wdata.
    - RS writes old | wdata.
    - RC writes old & ~wdata.
    - READ performs no write.
    - RS/RC with wdata=0 perform no write and raise no error.
  - RSP: pulse rsp_valid for one cycle on the granted port only, with rdata and err. Return to IDLE.
  - The other port's rsp outputs stay 0.
  - Latency: transfer at cycle T gives the response at T+3. Throughput is one access per 4 cycles.
- Errors:
  - Illegal address: rdata=0, err=1, no write.
  - A write attempt to a read-only shadow gives err=1, no write, and rdata returns the old value.
  - READ of a legal address always gives err=0.
- Read value is the value sampled in the RD cycle, i.e. before this access's write and including increments up to then.
- Write to mcountinhibit takes effect from the cycle after WR.
- Reset mid-operation: everything returns to reset values. The outstanding request is dropped with no response.
- rdata and err outputs hold their last values between responses. They are valid only with rsp_valid.

Decomposition:
- csr_pkg holds:
  - the op enum (CSR_READ/RW/RS/RC),
  - the FSM state enum,
  - address localparams (mcycle, mcycleh, minstret, minstreth, mcountinhibit, cycle/instret shadows),
  - the CY/IR bit indices.
- Sub-module csr_counter64, instantiated twice.
  - Inputs: clock, reset, increment enable, write-low, write-high, write data.
  - Output: the 64-bit count.
  - Write takes priority over increment.

Test Plan:
- Reset, then idle 10 cycles with retire_i pulsed 3 times -> cycle_o=10 (±1 per reset release), instret_o=3; port 0 READ 0xB02 -> rsp0 at T+3 with rdata=3, err=0.
- Port 0 RW 0xB80, wdata=0x1 -> rsp rdata=0; afterwards cycle_o[63:32]=1 and low half keeps counting. Also preload mcycle=0xFFFFFFFF_FFFFFFFE -> wraps to 0 two cycles later.
- Both ports valid the same cycle, twice in a row -> port 0 granted first, port 1 second; responses at T+3 and T+7 on the correct ports only.
- Port 1 RS 0x320, wdata=0x5 -> counters frozen (cycle_o constant for 5 cycles); RC 0x320, wdata=0x1 -> mcycle resumes, minstret stays frozen.
- RW to 0x7C0 -> err=1, rdata=0; RW to 0xC00 -> err=1, no counter change; RS 0xC00 with wdata=0 -> err=0.
- Assert rst_i during WR of an RW to 0xB00 -> no rsp pulse, counter=0, next request is served normally.
